vec_bit_scatter: RTL

//  Inverse of bit-gather vectorization: accepts one WIDTH-bit vector word plus a lane mask and

---
 rtl/vec_bit_scatter.sv | 113 +++++++++++
 1 files changed

// File: rtl/vec_bit_scatter.sv
// Vector-to-bitstream scatter: one WIDTH-bit word + lane mask out as per-lane (idx, bit) writes.
// Optional VEC_SCATTER_BACK2BACK_EN: accept the next word on the final handshake (no bubble).
module vec_bit_scatter #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_mask,
    input  logic [1:0]       in_order,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_bit,
    output logic             out_last,
    output logic             busy
);

    localparam int HALF = (WIDTH + 1) / 2;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] mask_q;
    logic [1:0]       order_q;
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] lane_v;
    logic [WIDTH-1:0] cur_onehot;
    logic             found;
    logic             accept;
    logic             handshake;

    // Lane visited at sequence position k for a given order code.
    function automatic int seq_lane(input logic [1:0] ord, input int k);
        case (ord)
            2'd1:    return WIDTH - 1 - k;
            2'd2:    return (k < HALF) ? 2 * k : 2 * (k - HALF) + 1;
            default: return k;
        endcase
    endfunction

    // First still-pending lane in the selected sequence; the pending mask shrinks per handshake.
    always_comb begin
        cur_idx = '0;
        lane_v  = '0;
        found   = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            lane_v = IDX_W'(seq_lane(order_q, k));
            if (!found && mask_q[lane_v]) begin
                found   = 1'b1;
                cur_idx = lane_v;
            end
        end
    end

    assign cur_onehot = {{(WIDTH-1){1'b0}}, 1'b1} << cur_idx;

    assign out_valid = (state_q == EMIT);
    assign busy      = (state_q == EMIT);
    assign out_idx   = cur_idx;
    assign out_bit   = out_valid & data_q[cur_idx];
    assign out_last  = out_valid && ((mask_q & ~cur_onehot) == '0);
    assign handshake = out_valid & out_ready;

`ifdef VEC_SCATTER_BACK2BACK_EN
    assign in_ready = (state_q == IDLE) | (handshake & out_last);
`else
    assign in_ready = (state_q == IDLE);
`endif

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && (in_mask != '0)) state_d = EMIT;
            end
            EMIT: begin
                if (accept)                     state_d = (in_mask != '0) ? EMIT : IDLE;
                else if (handshake && out_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            mask_q  <= '0;
            order_q <= '0;
        end else if (accept) begin
            data_q  <= in_data;
            mask_q  <= in_mask;
            order_q <= in_order;
        end else if (handshake) begin
            mask_q  <= mask_q & ~cur_onehot;
        end
    end

endmodule
